// File: rtl/block_transfer_seq_pkg.sv
// Shared state encoding, defaults and helpers for block_transfer_seq.
// The WB state exists only when BLOCK_TRANSFER_WBACK_EN is defined.
package blk_xfer_pkg;

    localparam int WORD_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
`ifdef BLOCK_TRANSFER_WBACK_EN
        ,
        ST_WB   = 2'd3
`endif
    } state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/block_transfer_seq_if.sv
// Word-memory request and register-file access bundle of the block transfer sequencer.
interface block_transfer_seq_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;
    logic [3:0]        rf_rA;
    logic [31:0]       rf_rD;
    logic              rf_wEn;
    logic [3:0]        rf_wA;
    logic [31:0]       rf_wD;

    modport master (
        output mem_addr, mem_we, mem_wd, rf_rA, rf_wEn, rf_wA, rf_wD,
        input  mem_rd, rf_rD
    );

    modport slave (
        input  mem_addr, mem_we, mem_wd, rf_rA, rf_wEn, rf_wA, rf_wD,
        output mem_rd, rf_rD
    );
endinterface

// File: rtl/block_transfer_seq_prio_enc16.sv
// Lowest-set-bit priority encoder: returns the index of the lowest 1 in mask and whether any bit is set.
module prio_enc16 (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        valid
);

    always_comb begin
        idx   = '0;
        valid = |mask;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/block_transfer_seq.sv
// LDM/STM-style block transfer sequencer: moves the registers in reglist to/from consecutive words.
// Base writeback (WB state) is built only when BLOCK_TRANSFER_WBACK_EN is defined.
module block_transfer_seq
    import blk_xfer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = WORD_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load,
    input  logic [15:0]       reglist,
    input  logic [ADDR_W-1:0] base,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    input  logic [3:0]        rn,
    output logic              busy,
    output logic              done,
    block_transfer_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_e            state_q, state_d;
    logic [15:0]       mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [4:0]        n_sel;
    logic [ADDR_W-1:0] span;
    logic [3:0]        enc_idx;
    logic              enc_valid;
    logic              in_xfer;
    logic              in_wb;
    logic [3:0]        wb_addr;
    logic [31:0]       wb_data;

`ifdef BLOCK_TRANSFER_WBACK_EN
    logic [3:0]        rn_q, rn_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_val_q, wb_val_d;

    assign in_wb   = (state_q == ST_WB);
    assign wb_addr = rn_q;
    assign wb_data = 32'(wb_val_q);
`else
    logic unused_wb_inputs;

    assign unused_wb_inputs = ^{wback, rn};
    assign in_wb   = 1'b0;
    assign wb_addr = '0;
    assign wb_data = '0;
`endif

    prio_enc16 u_enc (
        .mask  (mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        load_d  = load_q;
`ifdef BLOCK_TRANSFER_WBACK_EN
        rn_d     = rn_q;
        wb_en_d  = wb_en_q;
        wb_val_d = wb_val_q;
`endif
        n_sel = popcount16(reglist);
        span  = STEP * ADDR_W'(n_sel);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_d = load;
                    mask_d = reglist;
                    case ({up, pre})
                        2'b10:   addr_d = base;
                        2'b11:   addr_d = base + STEP;
                        2'b01:   addr_d = base - span;
                        default: addr_d = base - span + STEP;
                    endcase
`ifdef BLOCK_TRANSFER_WBACK_EN
                    rn_d     = rn;
                    // A load into the base register itself must win over the writeback.
                    wb_en_d  = wback && !(load && reglist[rn]);
                    wb_val_d = up ? (base + span) : (base - span);
`endif
                    state_d = (n_sel == 5'd0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                mask_d = mask_q & ~(16'd1 << enc_idx);
                addr_d = addr_q + STEP;
                if ((mask_d == 16'd0) || !enc_valid) begin
`ifdef BLOCK_TRANSFER_WBACK_EN
                    state_d = wb_en_q ? ST_WB : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef BLOCK_TRANSFER_WBACK_EN
            ST_WB: begin
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_XFER);
`ifdef BLOCK_TRANSFER_WBACK_EN
        busy_d = busy_d || (state_d == ST_WB);
`endif
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            addr_q   <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BLOCK_TRANSFER_WBACK_EN
            rn_q     <= '0;
            wb_en_q  <= 1'b0;
            wb_val_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BLOCK_TRANSFER_WBACK_EN
            rn_q     <= rn_d;
            wb_en_q  <= wb_en_d;
            wb_val_q <= wb_val_d;
`endif
        end
    end

    // Address and register index come only from flops so the external read path stays loop-free.
    assign in_xfer      = (state_q == ST_XFER);
    assign bus.mem_addr = in_xfer ? addr_q : '0;
    assign bus.mem_we   = in_xfer && !load_q;
    assign bus.mem_wd   = (in_xfer && !load_q) ? bus.rf_rD : '0;
    assign bus.rf_rA    = (in_xfer && !load_q) ? enc_idx : '0;
    assign bus.rf_wEn   = (in_xfer && load_q) || in_wb;
    assign bus.rf_wA    = (in_xfer && load_q) ? enc_idx : (in_wb ? wb_addr : '0);
    assign bus.rf_wD    = (in_xfer && load_q) ? bus.mem_rd : (in_wb ? wb_data : '0);

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_block_transfer_seq.sv
// Self-checking bench for block_transfer_seq: directed and random transfers against a transaction-level model.
module tb_block_transfer_seq;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wd;
        logic [3:0]  rf_rA;
        logic        rf_wEn;
        logic [3:0]  rf_wA;
        logic [31:0] rf_wD;
    } cycle_t;

    typedef struct packed {
        cycle_t exp;
        cycle_t care;
    } step_t;

`ifdef BLOCK_TRANSFER_WBACK_EN
    localparam bit WBACK_EN = 1'b1;
`else
    localparam bit WBACK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        load;
    logic [15:0] reglist;
    logic [31:0] base;
    logic        up;
    logic        pre;
    logic        wback;
    logic [3:0]  rn;
    logic        busy;
    logic        done;
    logic [31:0] rf_vals [16];
    int          checks;
    int          errors;

    block_transfer_seq_if #(.ADDR_W(32)) bus ();

    block_transfer_seq #(
        .ADDR_W     (32),
        .WORD_BYTES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .load    (load),
        .reglist (reglist),
        .base    (base),
        .up      (up),
        .pre     (pre),
        .wback   (wback),
        .rn      (rn),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.mem_rd = mem_val(bus.mem_addr);
    assign bus.rf_rD  = rf_vals[bus.rf_rA];

    function automatic step_t exp_idle();
        step_t s;
        s.exp  = '0;
        s.care = '1;
        return s;
    endfunction

    function automatic step_t exp_done();
        step_t s;
        s = exp_idle();
        s.exp.done = 1'b1;
        return s;
    endfunction

    function automatic step_t exp_stm(input logic [31:0] a, input int r);
        step_t s;
        s = exp_idle();
        s.exp.busy     = 1'b1;
        s.exp.mem_we   = 1'b1;
        s.exp.mem_addr = a;
        s.exp.mem_wd   = rf_vals[r];
        s.exp.rf_rA    = 4'(r);
        s.care.rf_wA   = '0;
        s.care.rf_wD   = '0;
        return s;
    endfunction

    function automatic step_t exp_ldm(input logic [31:0] a, input int r);
        step_t s;
        s = exp_idle();
        s.exp.busy     = 1'b1;
        s.exp.mem_addr = a;
        s.exp.rf_wEn   = 1'b1;
        s.exp.rf_wA    = 4'(r);
        s.exp.rf_wD    = mem_val(a);
        s.care.mem_wd  = '0;
        s.care.rf_rA   = '0;
        return s;
    endfunction

    function automatic step_t exp_wb(input logic [3:0] r, input logic [31:0] v);
        step_t s;
        s = exp_idle();
        s.exp.busy      = 1'b1;
        s.exp.rf_wEn    = 1'b1;
        s.exp.rf_wA     = r;
        s.exp.rf_wD     = v;
        s.care.mem_addr = '0;
        s.care.mem_wd   = '0;
        s.care.rf_rA    = '0;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input step_t s);
        cycle_t o;
        o.busy     = busy;
        o.done     = done;
        o.mem_we   = bus.mem_we;
        o.mem_addr = bus.mem_addr;
        o.mem_wd   = bus.mem_wd;
        o.rf_rA    = bus.rf_rA;
        o.rf_wEn   = bus.rf_wEn;
        o.rf_wA    = bus.rf_wA;
        o.rf_wD    = bus.rf_wD;
        checks++;
        assert ((o & s.care) === (s.exp & s.care)) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, o & s.care, s.exp & s.care);
        end
    endtask

    task automatic scramble_inputs();
        start   = 1'($urandom);
        load    = 1'($urandom);
        reglist = 16'($urandom);
        base    = $urandom;
        up      = 1'($urandom);
        pre     = 1'($urandom);
        wback   = 1'($urandom);
        rn      = 4'($urandom);
    endtask

    // Called at a falling edge; returns at a falling edge with the sequencer back in IDLE.
    task automatic applyStimulus(input string name, input logic ld, input logic [15:0] rl,
                                 input logic [31:0] b, input logic u, input logic p,
                                 input logic w, input logic [3:0] r);
        step_t       q[$];
        int          n;
        logic [31:0] a;
        n = $countones(rl);
        if (u) a = p ? b + 32'd4 : b;
        else   a = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                q.push_back(ld ? exp_ldm(a, i) : exp_stm(a, i));
                a = a + 32'd4;
            end
        end
        if (WBACK_EN && w && !(ld && rl[r])) begin
            q.push_back(exp_wb(r, u ? b + 32'(4 * n) : b - 32'(4 * n)));
        end
        q.push_back(exp_done());
        q.push_back(exp_idle());

        load = ld; reglist = rl; base = b; up = u; pre = p; wback = w; rn = r; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < q.size(); k++) begin
            if (k < q.size() - 1) scramble_inputs();
            else                  start = 1'b0;
            #1;
            checkOutput($sformatf("%s[%0d]", name, k), q[k]);
            if (k < q.size() - 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) rf_vals[i] = $urandom;
        reset = 1'b1; start = 1'b0; load = 1'b0; reglist = '0; base = '0;
        up = 1'b0; pre = 1'b0; wback = 1'b0; rn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 checkOutput("reset", exp_idle());
        reset = 1'b0;

        applyStimulus("stm_ia",   1'b0, 16'h000D, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus("ldm_db",   1'b1, 16'h8003, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 4'd13);
        applyStimulus("ldm_rnin", 1'b1, 16'h0004, 32'h0000_0400, 1'b1, 1'b0, 1'b1, 4'd2);
        applyStimulus("empty",    1'b0, 16'h0000, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 4'd3);
        applyStimulus("wrap_lo",  1'b0, 16'h0007, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 4'd1);
        applyStimulus("wrap_hi",  1'b1, 16'h0030, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1, 4'd9);
        applyStimulus("da_all",   1'b1, 16'hFFFF, 32'h0000_1000, 1'b0, 1'b0, 1'b1, 4'd4);

        load = 1'b0; reglist = 16'h00F0; base = 32'h0000_0300;
        up = 1'b1; pre = 1'b0; wback = 1'b0; rn = 4'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1 checkOutput("rst_x1", exp_stm(32'h0000_0300, 4));
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        #1 checkOutput("rst_x2", exp_stm(32'h0000_0304, 5));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1 checkOutput("rst_after", exp_idle());
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1 checkOutput($sformatf("rst_quiet%0d", i), exp_idle());
        end

        for (int t = 0; t < 24; t++) begin
            logic [15:0] rl;
            rl = 16'($urandom);
            if (t % 3 == 0) rl = rl & 16'($urandom);
            applyStimulus($sformatf("rnd%0d", t), 1'($urandom), rl, $urandom,
                          1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
